// File: rtl/sram_0rw1r1w_param_if.sv
// rtl/sram_0rw1r1w_param_if.sv - write/read port bundle for sram_0rw1r1w_param
interface sram_0rw1r1w_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4
);
    logic                  csb0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  dout1_valid;
    logic                  init_done;

    modport master (
        output csb0, addr0, din0, wmask0, csb1, addr1,
        input  dout1, dout1_valid, init_done
    );

    modport slave (
        input  csb0, addr0, din0, wmask0, csb1, addr1,
        output dout1, dout1_valid, init_done
    );
endinterface

// File: rtl/sram_0rw1r1w_param.sv
// rtl/sram_0rw1r1w_param.sv - 1W/1R SRAM with self-clear, lane masks, 1/2-cycle reads; optional SRAM_WR_FWD_EN
module sram_0rw1r1w_param #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int NUM_WMASKS   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk0,
    input  logic                 rst0,
    sram_0rw1r1w_param_if.slave  bus
);
    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANE_W    = DATA_WIDTH / NUM_WMASKS;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    if (DATA_WIDTH % NUM_WMASKS != 0) begin : g_bad_wmask
        $error("DATA_WIDTH must be a multiple of NUM_WMASKS");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end

    typedef enum logic {S_INIT = 1'b0, S_READY = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_next;
    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

    logic                  w_ready;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_rd_old;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_out_valid;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;

    // State and clear-counter register; reset always restarts clearing at word 0
    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Walk the clear counter across the whole array, then settle in READY
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (r_state == S_INIT) begin
            w_cnt_next = r_cnt + 1'b1;
            if (r_cnt == LAST_ADDR) begin
                w_state_next = S_READY;
            end
        end
    end

    assign w_ready = (r_state == S_READY);
    assign w_wr_en = w_ready && !bus.csb0;
    assign w_rd_en = w_ready && !bus.csb1;

    // Array write port: zero-fill while clearing, lane-masked user writes once ready
    always_ff @(posedge clk0) begin
        if (!rst0) begin
            if (r_state == S_INIT) begin
                r_mem[r_cnt] <= '0;
            end else if (!bus.csb0) begin
                for (int i = 0; i < NUM_WMASKS; i++) begin
                    if (bus.wmask0[i]) begin
                        r_mem[bus.addr0][i*LANE_W +: LANE_W] <= bus.din0[i*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    assign w_rd_old = r_mem[bus.addr1];

`ifdef SRAM_WR_FWD_EN
    // A same-edge write to the read address is merged into the read result lane by lane
    always_comb begin
        w_rd_data = w_rd_old;
        if (w_wr_en && (bus.addr0 == bus.addr1)) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (bus.wmask0[i]) begin
                    w_rd_data[i*LANE_W +: LANE_W] = bus.din0[i*LANE_W +: LANE_W];
                end
            end
        end
    end
`else
    assign w_rd_data = w_rd_old;
`endif

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_p1_valid;
        logic [DATA_WIDTH-1:0] r_p1_data;

        // Extra pipeline stage; accepts a new read every clock and is flushed by reset
        always_ff @(posedge clk0) begin
            if (rst0) begin
                r_p1_valid <= 1'b0;
                r_p1_data  <= '0;
            end else begin
                r_p1_valid <= w_rd_en;
                if (w_rd_en) begin
                    r_p1_data <= w_rd_data;
                end
            end
        end

        assign w_out_valid = r_p1_valid;
        assign w_out_data  = r_p1_data;
    end else begin : g_lat1
        assign w_out_valid = w_rd_en;
        assign w_out_data  = w_rd_data;
    end

    // Output register: new data only with a valid result, otherwise hold the last word
    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_out_valid;
            if (w_out_valid) begin
                r_dout <= w_out_data;
            end
        end
    end

    assign bus.dout1       = r_dout;
    assign bus.dout1_valid = r_dout_valid;
    assign bus.init_done   = w_ready;
endmodule
